// File: rtl/rp_bus_pkg.sv
// rp_bus_pkg
// Shared types and constants for the rp32 program/data bus arbiter.
//   arb_st_t : grant state machine states
//   own_t    : which master owns the read-data return path next cycle
//   RR_RST   : round-robin pointer value after reset (1 = data master first)
package rp_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_P,
    LOCK_D
  } arb_st_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P,
    OWN_D
  } own_t;

  localparam logic RR_RST = 1'b1;

endpackage

// File: rtl/rp_bus_cnt.sv
// rp_bus_cnt
// CW-bit saturating up-counter used to count per-master stall cycles.
// Ports:
//   clk_i   : clock, rising edge
//   clr_ni  : synchronous active-low clear
//   inc_i   : increment enable for this cycle
//   cnt_o   : current count, sticks at all ones
module rp_bus_cnt #(
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          clr_ni,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: add one only while enabled and not yet at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Count register; clear has priority over any increment.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rp_bus_arb.sv
// rp_bus_arb
// Merges the rp32 program bus (bup_*) and data bus (bud_*) onto one shared
// memory port (bum_*), giving a unified program/data memory.
// Ports:
//   clk, rst                : clock and synchronous active-low reset
//   bup_req/adr, bup_rdt/ack: program master (read only)
//   bud_req/wen/sel/adr/wdt,
//   bud_rdt/ack             : data master
//   bum_req/wen/sel/adr/wdt : shared port request fields (combinational)
//   bum_rdt/ack             : shared port response
//   cnt_p, cnt_d            : saturating stall counters per master
// Grant is combinational from the requests and the lock state, held until
// the memory acks, and alternates round-robin when both masters collide.
module rp_bus_arb
  import rp_bus_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bup_req,
  input  logic [AW-1:0] bup_adr,
  output logic [DW-1:0] bup_rdt,
  output logic          bup_ack,
  input  logic          bud_req,
  input  logic          bud_wen,
  input  logic [SW-1:0] bud_sel,
  input  logic [AW-1:0] bud_adr,
  input  logic [DW-1:0] bud_wdt,
  output logic [DW-1:0] bud_rdt,
  output logic          bud_ack,
  output logic          bum_req,
  output logic          bum_wen,
  output logic [SW-1:0] bum_sel,
  output logic [AW-1:0] bum_adr,
  output logic [DW-1:0] bum_wdt,
  input  logic [DW-1:0] bum_rdt,
  input  logic          bum_ack,
  output logic [CW-1:0] cnt_p,
  output logic [CW-1:0] cnt_d
);

  arb_st_t st_q, st_d;
  logic    rr_q, rr_d;
  own_t    own_q, own_d;
  logic    gnt_prg, gnt_dat;

  // Grant selection plus next-state logic. A locked master keeps the grant
  // only while it still requests; dropping req mid-lock releases the port
  // with no transfer and leaves the round-robin pointer alone. Holding reset
  // kills every grant, which in turn forces req/ack outputs low.
  always_comb begin
    gnt_prg = 1'b0;
    gnt_dat = 1'b0;
    st_d    = IDLE;
    rr_d    = rr_q;
    own_d   = OWN_NONE;

    case (st_q)
      LOCK_P:  gnt_prg = bup_req;
      LOCK_D:  gnt_dat = bud_req;
      default: begin
        if (bup_req && bud_req) begin
          gnt_dat = rr_q;
          gnt_prg = !rr_q;
        end else begin
          gnt_prg = bup_req;
          gnt_dat = bud_req;
        end
      end
    endcase

    if (!rst) begin
      gnt_prg = 1'b0;
      gnt_dat = 1'b0;
    end

    if (gnt_prg) begin
      if (bum_ack) begin
        rr_d  = 1'b1;
        own_d = OWN_P;
      end else begin
        st_d = LOCK_P;
      end
    end else if (gnt_dat) begin
      if (bum_ack) begin
        rr_d  = 1'b0;
        own_d = OWN_D;
      end else begin
        st_d = LOCK_D;
      end
    end
  end

  // Arbiter state registers; reset abandons any lock and favours data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= IDLE;
      rr_q  <= RR_RST;
      own_q <= OWN_NONE;
    end else begin
      st_q  <= st_d;
      rr_q  <= rr_d;
      own_q <= own_d;
    end
  end

  // The program master only reads full words, so its grant presents a
  // read with all byte lanes enabled and zero write data.
  assign bum_req = (gnt_prg & bup_req) | (gnt_dat & bud_req);
  assign bum_wen = gnt_dat ? bud_wen : 1'b0;
  assign bum_sel = gnt_dat ? bud_sel : {SW{1'b1}};
  assign bum_adr = gnt_dat ? bud_adr : bup_adr;
  assign bum_wdt = gnt_dat ? bud_wdt : '0;

  assign bup_ack = gnt_prg & bum_ack;
  assign bud_ack = gnt_dat & bum_ack;

  // Read data goes to whoever transferred last cycle; the other sees zero.
  assign bup_rdt = (rst && (own_q == OWN_P)) ? bum_rdt : '0;
  assign bud_rdt = (rst && (own_q == OWN_D)) ? bum_rdt : '0;

  rp_bus_cnt #(.CW(CW)) u_cnt_p (
    .clk_i  (clk),
    .clr_ni (rst),
    .inc_i  (bup_req & ~bup_ack),
    .cnt_o  (cnt_p)
  );

  rp_bus_cnt #(.CW(CW)) u_cnt_d (
    .clk_i  (clk),
    .clr_ni (rst),
    .inc_i  (bud_req & ~bud_ack),
    .cnt_o  (cnt_d)
  );

endmodule
